// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV64M multiply/divide sequencer.
// ALU_ADD/ALU_SUB match the encoding used by the shared ALU decoder.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    ITER   = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } muldiv_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // rs2 is signed for MUL/MULH/DIV/REM; rs1 additionally for MULHSU.
  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f3);
    return rs2_signed(f3) || (f3 == F3_MULHSU);
  endfunction

  function automatic logic is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_quot(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU);
  endfunction

  function automatic logic is_mul_hi(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_special_detect.sv
// Combinational detection of ops whose result needs no iteration:
// divide by zero, signed overflow (min / -1) and illegal word multiplies.
module muldiv_special_detect
  import muldiv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [2:0]   funct3,
  input  logic         word,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  output logic         special,
  output logic [N-1:0] special_data
);

  logic [N-1:0] rs1_ext;
  logic         div_op;
  logic         div_zero;
  logic         div_ovf;
  logic         bad_word;

  always_comb begin
    div_op   = is_quot(funct3) || is_rem(funct3);
    rs1_ext  = word ? {{(N-32){rs1[31]}}, rs1[31:0]} : rs1;
    div_zero = div_op && (word ? (rs2[31:0] == 32'd0) : (rs2 == '0));
    // Overflow only exists for the signed flavours (funct3[0] == 0).
    div_ovf  = div_op && !funct3[0] &&
               (word ? ((rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == 32'hFFFF_FFFF))
                     : ((rs1 == {1'b1, {(N-1){1'b0}}}) && (rs2 == '1)));
    bad_word = word && !div_op && (funct3 != F3_MUL);
    special  = div_zero || div_ovf || bad_word;

    special_data = '0;
    if (div_zero) begin
      special_data = is_rem(funct3) ? rs1_ext : '1;
    end else if (div_ovf) begin
      special_data = is_rem(funct3) ? '0 : rs1_ext;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV64M MUL/DIV unit that borrows the shared ALU one add/sub per cycle.
// Optional MULDIV_FLUSH_EN adds a `flush` input that abandons the current op.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef MULDIV_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_funct3,
  input  logic          req_word,
  input  logic [N-1:0]  req_rs1,
  input  logic [N-1:0]  req_rs2,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N-1:0]  resp_data,
  output logic          busy,
  output logic [N-1:0]  alu_dataA,
  output logic [N-1:0]  alu_dataB,
  output logic [3:0]    alu_control,
  output logic          alu_word,
  input  logic [N-1:0]  alu_out,
  input  logic          alu_carry,
  output muldiv_state_e dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is high only in IDLE; resp_valid is high only in DONE and the
  // response stays unchanged until it is taken; neither side may retract.

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] K_FULL = CW'(N - 1);
  localparam logic [CW-1:0] K_WORD = CW'(31);

  muldiv_state_e state, state_nx;

  logic [2:0]    f3_q;
  logic          word_q;
  logic [N-1:0]  opnd_q;   // multiplicand or divisor
  logic [N-1:0]  hi_q;     // product high half or partial remainder
  logic [N-1:0]  lo_q;     // multiplier/product low half or dividend/quotient
  logic [CW-1:0] cnt_q;
  logic          neg_b_q;
  logic          neg_lo_q;
  logic          neg_hi_q;
  logic          hi_cin_q;
  logic          special_q;
  logic          flush_i;

`ifdef MULDIV_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  function automatic logic [N-1:0] sext32(input logic [31:0] v);
    return {{(N-32){v[31]}}, v};
  endfunction

  function automatic logic [N-1:0] wmask(input logic w, input logic [N-1:0] v);
    return w ? {{(N-32){1'b0}}, v[31:0]} : v;
  endfunction

  // Request decode, used only when capturing in IDLE.
  logic         div_req;
  logic [N-1:0] rs1_z;
  logic [N-1:0] rs2_z;
  logic         neg1;
  logic         neg2;
  logic         neg_res;
  logic         special;
  logic [N-1:0] special_data;

  always_comb begin
    div_req = req_funct3[2];
    rs1_z   = wmask(req_word, req_rs1);
    rs2_z   = wmask(req_word, req_rs2);
    neg1    = rs1_signed(req_funct3) && (req_word ? req_rs1[31] : req_rs1[N-1]);
    neg2    = rs2_signed(req_funct3) && (req_word ? req_rs2[31] : req_rs2[N-1]);
    neg_res = is_rem(req_funct3) ? neg1 : (neg1 ^ neg2);
  end

  muldiv_special_detect #(.N(N)) u_special (
    .funct3       (req_funct3),
    .word         (req_word),
    .rs1          (req_rs1),
    .rs2          (req_rs2),
    .special      (special),
    .special_data (special_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (special)   state_nx = DONE;
          else if (neg1) state_nx = NEG_A;
          else if (neg2) state_nx = NEG_B;
          else           state_nx = ITER;
        end
      end
      NEG_A:  state_nx = neg_b_q ? NEG_B : ITER;
      NEG_B:  state_nx = ITER;
      ITER: begin
        if (cnt_q == '0) state_nx = neg_lo_q ? NEG_LO : (neg_hi_q ? NEG_HI : DONE);
      end
      NEG_LO: state_nx = neg_hi_q ? NEG_HI : DONE;
      NEG_HI: state_nx = DONE;
      DONE:   if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush_i) state_nx = IDLE;
  end

  // ALU operand steering; idle states present add 0+0.
  always_comb begin
    alu_dataA   = '0;
    alu_dataB   = '0;
    alu_control = ALU_ADD;
    alu_word    = 1'b0;
    case (state)
      NEG_A: begin
        alu_control = ALU_SUB;
        alu_dataB   = f3_q[2] ? lo_q : opnd_q;
      end
      NEG_B: begin
        alu_control = ALU_SUB;
        alu_dataB   = f3_q[2] ? opnd_q : lo_q;
      end
      ITER: begin
        if (f3_q[2]) begin
          alu_control = ALU_SUB;
          alu_dataA   = {hi_q[N-2:0], lo_q[N-1]};
          alu_dataB   = opnd_q;
        end else begin
          alu_dataA   = hi_q;
          alu_dataB   = lo_q[0] ? opnd_q : '0;
        end
      end
      NEG_LO: begin
        alu_control = ALU_SUB;
        alu_dataB   = lo_q;
      end
      NEG_HI: begin
        alu_dataA   = ~hi_q;
        alu_dataB   = {{(N-1){1'b0}}, hi_cin_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q      <= '0;
      word_q    <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_b_q   <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      hi_cin_q  <= 1'b0;
      special_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush_i) begin
            f3_q      <= req_funct3;
            word_q    <= req_word;
            cnt_q     <= req_word ? K_WORD : K_FULL;
            neg_b_q   <= neg2;
            neg_lo_q  <= neg_res && !is_rem(req_funct3);
            neg_hi_q  <= neg_res && (is_rem(req_funct3) || is_mul_hi(req_funct3));
            // REM skips NEG_LO, so NEG_HI must see a +1 to complete -hi.
            hi_cin_q  <= 1'b1;
            special_q <= special;
            hi_q      <= '0;
            if (special) begin
              lo_q <= special_data;
            end else if (div_req) begin
              opnd_q <= rs2_z;
              // Word dividend sits in the top half so 32 shifts consume it.
              lo_q   <= req_word ? {req_rs1[31:0], {(N-32){1'b0}}} : req_rs1;
            end else begin
              opnd_q <= rs1_z;
              lo_q   <= rs2_z;
            end
          end
        end
        NEG_A: begin
          if (f3_q[2]) lo_q   <= alu_out;
          else         opnd_q <= wmask(word_q, alu_out);
        end
        NEG_B: begin
          if (f3_q[2]) opnd_q <= wmask(word_q, alu_out);
          else         lo_q   <= wmask(word_q, alu_out);
        end
        ITER: begin
          cnt_q <= cnt_q - CW'(1);
          if (f3_q[2]) begin
            // Restoring step; bit shifted out of R means R' >= D regardless.
            if (alu_carry || hi_q[N-1]) begin
              hi_q <= alu_out;
              lo_q <= {lo_q[N-2:0], 1'b1};
            end else begin
              hi_q <= {hi_q[N-2:0], lo_q[N-1]};
              lo_q <= {lo_q[N-2:0], 1'b0};
            end
          end else begin
            hi_q <= {alu_carry, alu_out[N-1:1]};
            lo_q <= {alu_out[0], lo_q[N-1:1]};
          end
        end
        NEG_LO: begin
          lo_q     <= alu_out;
          hi_cin_q <= (lo_q == '0);
        end
        NEG_HI: hi_q <= alu_out;
        default: ;
      endcase
    end
  end

  logic [N-1:0] result;

  always_comb begin
    result = '0;
    if (special_q)              result = lo_q;
    else if (f3_q == F3_MUL)    result = word_q ? sext32(lo_q[N-1:N-32]) : lo_q;
    else if (is_mul_hi(f3_q))   result = hi_q;
    else if (is_quot(f3_q))     result = word_q ? sext32(lo_q[31:0]) : lo_q;
    else                        result = word_q ? sext32(hi_q[31:0]) : hi_q;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_data  = (state == DONE) ? result : '0;
  assign busy       = (state != IDLE) && (state != DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with a behavioural shared ALU.
// Optional flush test is compiled in with MULDIV_FLUSH_EN.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic          req_word;
  logic [63:0]   req_rs1;
  logic [63:0]   req_rs2;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   resp_data;
  logic          busy;
  logic [63:0]   alu_dataA;
  logic [63:0]   alu_dataB;
  logic [3:0]    alu_control;
  logic          alu_word;
  logic [63:0]   alu_out;
  logic          alu_carry;
  muldiv_state_e dbg_state;
`ifdef MULDIV_FLUSH_EN
  logic          flush;
`endif

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  muldiv_sequencer #(.N(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef MULDIV_FLUSH_EN
    .flush       (flush),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_word    (req_word),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .busy        (busy),
    .alu_dataA   (alu_dataA),
    .alu_dataB   (alu_dataB),
    .alu_control (alu_control),
    .alu_word    (alu_word),
    .alu_out     (alu_out),
    .alu_carry   (alu_carry),
    .dbg_state   (dbg_state)
  );

  // Shared ALU: add gives carry out, sub gives A >= B unsigned.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_control)
      4'b0000: {alu_carry, alu_out} = {1'b0, alu_dataA} + {1'b0, alu_dataB};
      4'b1000: begin
        alu_out   = alu_dataA - alu_dataB;
        alu_carry = (alu_dataA >= alu_dataB);
      end
      default: ;
    endcase
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input string name);
    vec_t v;
    v.f3 = f3; v.w = w; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  64'(req_ready),   64'd1);
    check({tag, "_resp_valid"}, 64'(resp_valid),  64'd0);
    check({tag, "_resp_data"},  resp_data,        64'd0);
    check({tag, "_busy"},       64'(busy),        64'd0);
    check({tag, "_alu_a"},      alu_dataA,        64'd0);
    check({tag, "_alu_b"},      alu_dataB,        64'd0);
    check({tag, "_alu_ctl"},    64'(alu_control), 64'd0);
    check({tag, "_alu_word"},   64'(alu_word),    64'd0);
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural RV64M reference built from native arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [31:0]  a32, b32, r32;
    logic [63:0]  r;
    logic         sgn, rem;
    a32 = a[31:0];
    b32 = b[31:0];
    if (!f3[2]) begin
      if (w) begin
        if (f3 != 3'b000) return 64'd0;
        r32 = a32 * b32;
        return sx32(r32);
      end
      pa = (f3 != 3'b011 && a[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, a} : {64'd0, a};
      pb = ((f3 == 3'b000 || f3 == 3'b001) && b[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, b} : {64'd0, b};
      p  = pa * pb;
      return (f3 == 3'b000) ? p[63:0] : p[127:64];
    end
    sgn = !f3[0];
    rem = f3[1];
    if (w) begin
      if (b32 == 32'd0)                                             r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
      else if (sgn) r32 = rem ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else          r32 = rem ? a32 % b32 : a32 / b32;
      return sx32(r32);
    end
    if (b == 64'd0)                                                 r = rem ? a : '1;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1)        r = rem ? 64'd0 : a;
    else if (sgn) r = rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    else          r = rem ? a % b : a / b;
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one op, score its response, optionally stall the consumer.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                        input int hold, input string name);
    int lat;
    logic [63:0] want;
    @(negedge clk);
    check({name, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_word   = w;
    req_rs1    = a;
    req_rs2    = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    if (exp_lat > 1)       check({name, "_busy"}, 64'(busy), 64'd1);
    else if (exp_lat == 1) check({name, "_busy"}, 64'(busy), 64'd0);
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_resp required=resp", name);
      void'(exp_q.pop_front());
      pulse_reset();
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard actual=resp required=empty_queue", name);
      want = '0;
    end else begin
      want = exp_q.pop_front();
      check({name, "_data"}, resp_data, want);
    end
    if (exp_lat != 0) check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_funct3 = 3'($urandom_range(0, 7));
      req_rs1    = {$urandom, $urandom};
      req_rs2    = {$urandom, $urandom};
      @(negedge clk);
      check({name, "_hold_data"},  resp_data,       want);
      check({name, "_hold_ready"}, 64'(req_ready),  64'd0);
      check({name, "_hold_valid"}, 64'(resp_valid), 64'd1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_ready"}, 64'(req_ready),  64'd1);
    check({name, "_idle_valid"}, 64'(resp_valid), 64'd0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 3))
      0: return 64'($signed(32'($urandom_range(0, 40))) - 20);
      1: return {$urandom, $urandom};
      2: begin
        case ($urandom_range(0, 3))
          0: return 64'd0;
          1: return '1;
          2: return 64'h8000_0000_0000_0000;
          default: return 64'h0000_0000_8000_0000;
        endcase
      end
      default: return {$urandom, 32'($urandom_range(0, 1) ? 32'hFFFF_FF00 | $urandom_range(0, 255) : $urandom_range(0, 300))};
    endcase
  endfunction

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = '0;
    req_word   = 1'b0;
    req_rs1    = '0;
    req_rs2    = '0;
    resp_ready = 1'b0;
`ifdef MULDIV_FLUSH_EN
    flush      = 1'b0;
`endif

    add_vec(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 67, "mul_7x-3");
    add_vec(3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65, "mulhu_2p63x4");
    add_vec(3'b001, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 67, "mulh_minx-1");
    add_vec(3'b010, 1'b0, '1, 64'd2, '1, 68, "mulhsu_-1x2");
    add_vec(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, '1, 68, "mulh_-3x5");
    add_vec(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, "div_-7/2");
    add_vec(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 0, "rem_-7/2");
    add_vec(3'b101, 1'b0, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, "divu_big");
    add_vec(3'b101, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, '1, 1, "divu_by0");
    add_vec(3'b110, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1, "rem_by0");
    add_vec(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_ovf");
    add_vec(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem_ovf");
    add_vec(3'b100, 1'b1, 64'h1_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    add_vec(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_max2");
    add_vec(3'b001, 1'b1, 64'd5, 64'd6, 64'd0, 1, "illegal_word");
    add_vec(3'b101, 1'b1, 64'hABCD_0000_0000_0064, 64'h5555_0000_0000_0007, 64'd14, 33, "divuw_100/7");
    add_vec(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h9999_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 35, "divw_-7/2");
    add_vec(3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h9999_0000_0000_0002, '1, 0, "remw_-7/2");
    add_vec(3'b111, 1'b0, 64'd1000, 64'd7, 64'd6, 65, "remu_1000/7");

    #1;
    check_reset_outputs("reset");
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, vecs[i].name);
    end

    // Consumer stall with new requests offered meanwhile.
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, 10, "hold_divu");

    // Asynchronous reset in the middle of the iteration.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b000; req_word = 1'b0;
    req_rs1 = 64'd12345; req_rs2 = 64'd678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("midop_state", 64'(dbg_state), 64'(ITER));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("midop_no_resp", 64'(seen), 64'd0);
    end

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 2) == 0);
      a  = pick_operand();
      b  = pick_operand();
      run_op(f3, w, a, b, ref_model(f3, w, a, b), 0, 0, "random");
    end

`ifdef MULDIV_FLUSH_EN
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b100; req_word = 1'b0;
    req_rs1 = 64'd999; req_rs2 = 64'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_state", 64'(dbg_state), 64'(IDLE));
    check("flush_busy",  64'(busy),      64'd0);
    check("flush_ready", 64'(req_ready), 64'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("flush_no_resp", 64'(seen), 64'd0);
    end
    run_op(3'b100, 1'b0, 64'd999, 64'd3, 64'd333, 65, 0, "after_flush");
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
